// File: rtl/max_sweep_ctrl.sv
// Sweep controller: issues a row-major grid of tiles to a PE array, counts
// returning results into the max registers, with abort and a result watchdog.
module max_sweep_ctrl #(
  parameter int NUM_TILE_ROWS = 4,
  parameter int NUM_TILE_COLS = 4,
  parameter int MAX_OUT       = 4,
  parameter int TIMEOUT       = 64,
  parameter int ROW_W         = 8,
  parameter int COL_W         = 8,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             tile_ready,
  output logic             tile_issue,
  output logic [ROW_W-1:0] tile_row,
  output logic [COL_W-1:0] tile_col,
  input  logic             res_valid,
  output logic             wr_en_max,
  output logic             clr_max,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] tiles_done
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUT);
  localparam logic [OUT_W-1:0] OUT_ONE  = OUT_W'(1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_TILE_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_TILE_COLS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

  state_t           state;
  logic [OUT_W-1:0] outstanding;
  logic [WD_W-1:0]  wdog;
  logic             sweeping;
  logic             res_err;
  logic             wd_fire;
  logic             last_tile;

  assign sweeping   = (state == RUN) || (state == DRAIN);
  assign tile_issue = !rst && (state == RUN) && tile_ready && (outstanding < OUT_MAX) && !abort;
  assign wr_en_max  = !rst && sweeping && res_valid && (outstanding != '0) && !abort;
  assign res_err    = res_valid && ((state == IDLE) || (state == CLEAR) || (outstanding == '0));
  // The watchdog fires on the edge where its count would reach TIMEOUT.
  assign wd_fire    = sweeping && !res_valid && (outstanding != '0) && (wdog == WD_LAST);
  assign last_tile  = (tile_row == LAST_ROW) && (tile_col == LAST_COL);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      outstanding <= '0;
      wdog        <= '0;
      tile_row    <= '0;
      tile_col    <= '0;
      tiles_done  <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      clr_max     <= 1'b0;
    end else begin
      done    <= 1'b0;
      clr_max <= 1'b0;
      if (res_err) err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= CLEAR;
            clr_max     <= 1'b1;
            err         <= 1'b0;
            tiles_done  <= '0;
            tile_row    <= '0;
            tile_col    <= '0;
            outstanding <= '0;
            wdog        <= '0;
          end
        end
        CLEAR: begin
          state <= abort ? IDLE : RUN;
        end
        RUN, DRAIN: begin
          if (abort) begin
            state       <= IDLE;
            outstanding <= '0;
            wdog        <= '0;
          end else if (wd_fire) begin
            state       <= IDLE;
            err         <= 1'b1;
            outstanding <= '0;
            wdog        <= '0;
          end else begin
            wdog <= (res_valid || (outstanding == '0)) ? '0 : wdog + 1'b1;
            if (tile_issue && !wr_en_max)
              outstanding <= outstanding + 1'b1;
            else if (!tile_issue && wr_en_max)
              outstanding <= outstanding - 1'b1;
            if (wr_en_max && (tiles_done != '1))
              tiles_done <= tiles_done + 1'b1;
            // Coordinates stay on the final tile once the grid is exhausted.
            if (tile_issue) begin
              if (last_tile) begin
                state <= DRAIN;
              end else if (tile_col == LAST_COL) begin
                tile_col <= '0;
                tile_row <= tile_row + 1'b1;
              end else begin
                tile_col <= tile_col + 1'b1;
              end
            end
            if ((state == DRAIN) && wr_en_max && (outstanding == OUT_ONE)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max_sweep_ctrl.sv
// Bench for max_sweep_ctrl: directed sweeps with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_max_sweep_ctrl;

  localparam int NR      = 2;
  localparam int NC      = 3;
  localparam int MAX_OUT = 2;
  localparam int TIMEOUT = 8;
  localparam int ROW_W   = 4;
  localparam int COL_W   = 4;
  localparam int CNT_W   = 2;
  localparam int TOTAL   = NR * NC;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic             tile_ready;
  logic             tile_issue;
  logic [ROW_W-1:0] tile_row;
  logic [COL_W-1:0] tile_col;
  logic             res_valid;
  logic             wr_en_max;
  logic             clr_max;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] tiles_done;

  int checks = 0;
  int errors = 0;

  // Behavioural model: grid position as a linear index, in-flight tiles in a queue.
  bit m_active, m_clear, m_done, m_err;
  int m_next, m_tiles, m_idle;
  int m_q[$];

  int t_res   [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
  int t_issue [9] = '{0, 0, 1, 1, 0, 1, 1, 1, 1};
  int t_row   [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
  int t_col   [9] = '{0, 0, 0, 1, 2, 2, 0, 1, 2};
  int t_wr    [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
  int t_tiles [9] = '{0, 0, 0, 0, 0, 1, 2, 3, 3};
  int t_clr   [9] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};

  max_sweep_ctrl #(
    .NUM_TILE_ROWS(NR), .NUM_TILE_COLS(NC), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT),
    .ROW_W(ROW_W), .COL_W(COL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .tile_ready(tile_ready),
    .tile_issue(tile_issue), .tile_row(tile_row), .tile_col(tile_col),
    .res_valid(res_valid), .wr_en_max(wr_en_max), .clr_max(clr_max),
    .busy(busy), .done(done), .err(err), .tiles_done(tiles_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit a, input bit r, input bit v);
    start      = s;
    abort      = a;
    tile_ready = r;
    res_valid  = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_active = 0; m_clear = 0; m_done = 0; m_err = 0;
    m_next = 0; m_tiles = 0; m_idle = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit issue, input bit wr);
    bit err_set;
    err_set = res_valid && (!m_active || m_clear || m_q.size() == 0);
    m_done = 0;
    if (!m_active) begin
      if (start) begin
        m_active = 1; m_clear = 1; m_next = 0; m_tiles = 0; m_err = 0; m_idle = 0;
        m_q.delete();
      end else if (err_set) begin
        m_err = 1;
      end
    end else begin
      if (err_set) m_err = 1;
      if (abort) begin
        m_active = 0; m_idle = 0;
        m_q.delete();
      end else if (m_clear) begin
        m_clear = 0;
      end else begin
        if (res_valid || m_q.size() == 0) m_idle = 0;
        else m_idle++;
        if (m_idle == TIMEOUT) begin
          m_err = 1; m_active = 0; m_idle = 0;
          m_q.delete();
        end else begin
          if (wr) begin
            void'(m_q.pop_front());
            m_tiles++;
          end
          if (issue) begin
            m_q.push_back(m_next);
            m_next++;
          end
          if (wr && m_next == TOTAL && m_q.size() == 0) begin
            m_active = 0;
            m_done   = 1;
          end
        end
      end
    end
  endtask

  // Per-cycle comparison of every output against the model, mid-cycle.
  always @(negedge clk) begin
    bit e_issue, e_wr;
    int cur;
    if (rst) begin
      checkOutput("rst_issue", tile_issue, 0);
      checkOutput("rst_wr", wr_en_max, 0);
      checkOutput("rst_row", tile_row, 0);
      checkOutput("rst_col", tile_col, 0);
      checkOutput("rst_tiles", tiles_done, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_clr", clr_max, 0);
      model_reset();
    end else begin
      e_issue = m_active && !m_clear && m_next < TOTAL && tile_ready
                && m_q.size() < MAX_OUT && !abort;
      e_wr    = m_active && !m_clear && res_valid && m_q.size() > 0 && !abort;
      cur     = (m_next < TOTAL) ? m_next : TOTAL - 1;
      checkOutput("model_issue", tile_issue, e_issue);
      checkOutput("model_wr", wr_en_max, e_wr);
      checkOutput("model_row", tile_row, cur / NC);
      checkOutput("model_col", tile_col, cur % NC);
      checkOutput("model_tiles", tiles_done, (m_tiles > SAT) ? SAT : m_tiles);
      checkOutput("model_busy", busy, m_active);
      checkOutput("model_clr", clr_max, m_active && m_clear);
      checkOutput("model_done", done, m_done);
      checkOutput("model_err", err, m_err);
      model_step(e_issue, e_wr);
    end
  end

  // Start a sweep from IDLE and run cycles 0..last of the reference pattern.
  task automatic sweep_head(input bit hs, input int last);
    for (int c = 0; c <= last; c++) begin
      applyStimulus((c == 0) ? 1'b1 : hs, 1'b0, 1'b1, t_res[c] != 0);
      @(negedge clk);
      checkOutput("sweep_issue", tile_issue, t_issue[c]);
      checkOutput("sweep_wr", wr_en_max, t_wr[c]);
      checkOutput("sweep_clr", clr_max, t_clr[c]);
      checkOutput("sweep_busy", busy, (c == 0) ? 0 : 1);
      if (c >= 1) begin
        checkOutput("sweep_row", tile_row, t_row[c]);
        checkOutput("sweep_col", tile_col, t_col[c]);
        checkOutput("sweep_tiles", tiles_done, t_tiles[c]);
      end
      tick();
    end
  endtask

  task automatic finish_sweep(input bit hs);
    applyStimulus(hs, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("drain_issue", tile_issue, 0);
    checkOutput("drain_wr", wr_en_max, 1);
    checkOutput("drain_done", done, 0);
    tick();
    applyStimulus(hs, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("done_pulse", done, 1);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_tiles", tiles_done, 3);
    checkOutput("done_err", err, 0);
    tick();
    @(negedge clk);
    checkOutput("done_once", done, 0);
    checkOutput("restart_clr", clr_max, hs);
    checkOutput("restart_busy", busy, hs);
    checkOutput("restart_err", err, 0);
    tick();
  endtask

  initial begin
    int hold;
    bit s, a, r, v;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Full sweep, then a sweep with start held high throughout.
    sweep_head(0, 8);
    finish_sweep(0);
    sweep_head(1, 8);
    finish_sweep(1);
    applyStimulus(0, 1, 1, 0);
    @(negedge clk);
    checkOutput("abort_run_issue", tile_issue, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("abort_run_busy", busy, 0);
    tick();

    // Abort in DRAIN with one tile outstanding, then a stray result.
    sweep_head(0, 8);
    applyStimulus(0, 1, 1, 0);
    @(negedge clk);
    checkOutput("abort_drain_issue", tile_issue, 0);
    checkOutput("abort_drain_busy", busy, 1);
    tick();
    applyStimulus(0, 0, 1, 0);
    @(negedge clk);
    checkOutput("abort_idle_busy", busy, 0);
    checkOutput("abort_no_done", done, 0);
    tick();
    applyStimulus(0, 0, 1, 1);
    @(negedge clk);
    checkOutput("stray_wr", wr_en_max, 0);
    tick();
    applyStimulus(0, 0, 1, 0);
    @(negedge clk);
    checkOutput("stray_err", err, 1);
    tick();

    // Watchdog: one tile issued, results never arrive.
    applyStimulus(1, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 1, 0);
    @(negedge clk);
    checkOutput("wd_clr", clr_max, 1);
    checkOutput("wd_err_cleared", err, 0);
    tick();
    @(negedge clk);
    checkOutput("wd_issue", tile_issue, 1);
    tick();
    for (int c = 3; c <= 10; c++) begin
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("wd_busy_wait", busy, 1);
      checkOutput("wd_err_wait", err, 0);
      tick();
    end
    @(negedge clk);
    checkOutput("wd_busy_fired", busy, 0);
    checkOutput("wd_err_fired", err, 1);
    checkOutput("wd_no_done", done, 0);
    tick();
    @(negedge clk);
    checkOutput("wd_no_done_late", done, 0);
    tick();

    // Reset mid-sweep after three issues, then a fresh sweep.
    sweep_head(0, 5);
    rst = 1'b1;
    applyStimulus(0, 0, 1, 1);
    @(negedge clk);
    checkOutput("mid_rst_issue", tile_issue, 0);
    checkOutput("mid_rst_wr", wr_en_max, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_col", tile_col, 0);
    checkOutput("mid_rst_tiles", tiles_done, 0);
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 1, 0);
    @(negedge clk);
    checkOutput("post_rst_done", done, 0);
    checkOutput("post_rst_busy", busy, 0);
    tick();
    sweep_head(0, 2);
    applyStimulus(0, 1, 0, 0);
    @(negedge clk);
    checkOutput("post_rst_abort_issue", tile_issue, 0);
    tick();

    // Randomized traffic; the per-cycle compare process does the checking.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 999) < 4);
      s = ($urandom_range(0, 99) < 30);
      a = ($urandom_range(0, 199) < 3);
      r = ($urandom_range(0, 99) < 70);
      if (hold > 0) begin
        v = 0;
        hold--;
      end else begin
        if ($urandom_range(0, 99) < 3) hold = $urandom_range(5, 12);
        v = (m_q.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 4);
      end
      if (!m_active && s) v = 0;
      applyStimulus(s, a, r, v);
      tick();
    end
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_sweep_ctrl.md
MAX_SWEEP_CTRL -- requirements
Module: max_sweep_ctrl

Interface
Parameters: name, default, meaning
REQ-001 SHALL have parameter NUM_TILE_ROWS, 4: number of tile rows in one sweep (>=1).
REQ-002 SHALL have parameter NUM_TILE_COLS, 4: number of tile columns in one sweep (>=1).
REQ-003 SHALL have parameter MAX_OUT, 4: maximum tiles issued but not yet returned (>=1).
REQ-004 SHALL have parameter TIMEOUT, 64: idle-result cycles before the watchdog fires (>=2).
REQ-005 SHALL have parameters ROW_W, 8 and COL_W, 8: tile coordinate widths.
REQ-006 SHALL have parameter CNT_W, 8: width of tiles_done.
Ports: name, direction, width, meaning
REQ-007 SHALL have clk, in, 1: single clock, all state on its rising edge.
REQ-008 SHALL have rst, in, 1: asynchronous, active-high reset.
REQ-009 SHALL have start, in, 1: request a sweep; accepted only in IDLE.
REQ-010 SHALL have abort, in, 1: cancel the sweep in progress.
REQ-011 SHALL have tile_ready, in, 1: PE array can take a tile this cycle.
REQ-012 SHALL have tile_issue, out, 1: tile handed to the array this cycle.
REQ-013 SHALL have tile_row, out, ROW_W and tile_col, out, COL_W: coordinates of the current tile.
REQ-014 SHALL have res_valid, in, 1: one tile's score/row/col result is present at the max registers; results return in order.
REQ-015 SHALL have wr_en_max, out, 1: write enable to the max registers.
REQ-016 SHALL have clr_max, out, 1: one-cycle clear for the max registers.
REQ-017 SHALL have busy, out, 1; done, out, 1; err, out, 1; tiles_done, out, CNT_W.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, RUN, DRAIN.
REQ-019 IDLE: start=1 -> CLEAR. In the accept cycle, err, tiles_done, tile_row, tile_col and the outstanding count SHALL be cleared.
REQ-020 CLEAR: clr_max=1 for exactly this one cycle, then -> RUN.
REQ-021 tile_issue SHALL be combinational: state==RUN and tile_ready and outstanding<MAX_OUT and abort==0.
REQ-022 Tile order SHALL be row-major: on each issue tile_col increments; at NUM_TILE_COLS-1 it wraps to 0 and tile_row increments.
REQ-023 Issue of tile (NUM_TILE_ROWS-1, NUM_TILE_COLS-1) SHALL move RUN -> DRAIN; tile_row and tile_col hold their last values.
REQ-024 Outstanding count SHALL increment on issue, decrement on an accepted result, and stay unchanged when both occur in the same cycle.
REQ-025 wr_en_max SHALL be combinational: res_valid and outstanding>0 and state in {RUN, DRAIN} and abort==0.
REQ-026 Each wr_en_max SHALL increment tiles_done, which saturates at all-ones.
REQ-027 DRAIN: the result that takes outstanding to 0 SHALL move the FSM -> IDLE, with done=1 for one cycle on the following cycle.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 res_valid with outstanding==0, or while in IDLE/CLEAR, SHALL set err and SHALL NOT assert wr_en_max.
REQ-030 Watchdog: the counter SHALL reset on any res_valid and whenever outstanding==0, and otherwise increment. When it reaches TIMEOUT: set err, go to IDLE, clear outstanding, and suppress done.
REQ-031 abort in CLEAR, RUN or DRAIN SHALL force IDLE on the next edge: no done, outstanding cleared, no issue or write in the abort cycle. abort in IDLE has no effect.
REQ-032 start while not in IDLE SHALL be ignored. start and abort together in IDLE: the start SHALL be accepted.
REQ-033 err SHALL be sticky until the next accepted start.

Reset
REQ-034 rst=1 SHALL asynchronously force IDLE and set these outputs/state to 0: outstanding, watchdog, tile_row, tile_col, tiles_done, busy, done, err, clr_max.
REQ-035 Combinational outputs tile_issue and wr_en_max SHALL be 0 while rst=1.
REQ-036 Reset mid-sweep SHALL produce no done pulse after release; a new start SHALL begin a fresh sweep from tile (0,0).

Verification
REQ-037 2x2 grid, tile_ready=1, res_valid 3 cycles after each issue -> clr_max in the cycle after start; issues (0,0),(0,1),(1,0),(1,1) on 4 consecutive cycles; 4 wr_en_max; one done pulse; tiles_done=4; err=0.
REQ-038 MAX_OUT=2, results withheld -> exactly 2 issues, then tile_issue=0 until a res_valid arrives; issue and result in the same cycle keep outstanding=2.
REQ-039 abort in DRAIN with 1 tile outstanding -> IDLE next cycle; no done; a later res_valid sets err with wr_en_max=0.
REQ-040 TIMEOUT=8, one tile issued, no result -> err=1 and busy=0 after 8 cycles; no done.
REQ-041 rst pulsed in RUN after 3 issues -> all outputs 0 immediately; the next start issues (0,0) first with tiles_done=0.
REQ-042 start held 1 through a whole sweep -> a second sweep starts only from IDLE, after the done cycle; err stays 0.
